// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1-style TAP controller: 16-state FSM, instruction register, BYPASS/IDCODE DRs, TDO mux.
// Define IDCODE_EN to include the IDCODE register and make OP_IDCODE the reset instruction.
module jtag_tap_ctrl #(
  parameter int unsigned          IR_WIDTH     = 4,
  parameter logic [IR_WIDTH-1:0]  OP_IDCODE    = 'b0001,
  parameter logic [IR_WIDTH-1:0]  OP_USER      = 'b0010,
  parameter logic [31:0]          IDCODE_VALUE = 32'h1234_5679
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_EN,
  output logic [3:0]          STATE,
  output logic [IR_WIDTH-1:0] IR,
  output logic                SEL_USER,
  output logic                CAPTURE_DR,
  output logic                SHIFT_DR,
  output logic                UPDATE_DR,
  input  logic                USER_TDO
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,  IDLE   = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
    SH_DR  = 4'd4,  EX1_DR = 4'd5,  PA_DR  = 4'd6,  EX2_DR = 4'd7,
    UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
    EX1_IR = 4'd12, PA_IR  = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } tap_state_t;

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);
`ifdef IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_DEFAULT = OP_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] IR_DEFAULT = '1;
`endif

  tap_state_t          state;
  logic [IR_WIDTH-1:0] ir_sr;
  logic                bypass_q;
  logic                dr_tdo;

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state <= TLR;
    end else begin
      case (state)
        TLR:    state <= TMS ? TLR    : IDLE;
        IDLE:   state <= TMS ? SEL_DR : IDLE;
        SEL_DR: state <= TMS ? SEL_IR : CAP_DR;
        CAP_DR: state <= TMS ? EX1_DR : SH_DR;
        SH_DR:  state <= TMS ? EX1_DR : SH_DR;
        EX1_DR: state <= TMS ? UPD_DR : PA_DR;
        PA_DR:  state <= TMS ? EX2_DR : PA_DR;
        EX2_DR: state <= TMS ? UPD_DR : SH_DR;
        UPD_DR: state <= TMS ? SEL_DR : IDLE;
        SEL_IR: state <= TMS ? TLR    : CAP_IR;
        CAP_IR: state <= TMS ? EX1_IR : SH_IR;
        SH_IR:  state <= TMS ? EX1_IR : SH_IR;
        EX1_IR: state <= TMS ? UPD_IR : PA_IR;
        PA_IR:  state <= TMS ? EX2_IR : PA_IR;
        EX2_IR: state <= TMS ? UPD_IR : SH_IR;
        UPD_IR: state <= TMS ? SEL_DR : IDLE;
      endcase
    end
  end

  assign STATE = state;

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      ir_sr <= IR_CAPTURE;
    end else if (state == CAP_IR) begin
      ir_sr <= IR_CAPTURE;
    end else if (state == SH_IR) begin
      ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};
    end
  end

  // Active instruction changes only on falling TCK, so decoded selects are stable across rising edges
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      IR <= IR_DEFAULT;
    end else if (state == TLR) begin
      IR <= IR_DEFAULT;
    end else if (state == UPD_IR) begin
      IR <= ir_sr;
    end
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      bypass_q <= 1'b0;
    end else if (state == CAP_DR) begin
      bypass_q <= 1'b0;
    end else if (state == SH_DR) begin
      bypass_q <= TDI;
    end
  end

  assign SEL_USER   = (IR == OP_USER);
  assign CAPTURE_DR = (state == CAP_DR) && SEL_USER;
  assign SHIFT_DR   = (state == SH_DR)  && SEL_USER;
  assign UPDATE_DR  = (state == UPD_DR) && SEL_USER;

`ifdef IDCODE_EN
  logic [31:0] idcode_sr;
  logic        sel_idcode;

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      idcode_sr <= IDCODE_VALUE;
    end else if (state == CAP_DR) begin
      idcode_sr <= IDCODE_VALUE;
    end else if (state == SH_DR) begin
      idcode_sr <= {TDI, idcode_sr[31:1]};
    end
  end

  assign sel_idcode = (IR == OP_IDCODE) && !SEL_USER;
  assign dr_tdo     = SEL_USER ? USER_TDO : (sel_idcode ? idcode_sr[0] : bypass_q);
`else
  logic unused_idcode;
  assign unused_idcode = ^{IDCODE_VALUE, OP_IDCODE};
  assign dr_tdo        = SEL_USER ? USER_TDO : bypass_q;
`endif

  // TDO launches on falling TCK so the host samples a settled bit on the next rising edge
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
    end else begin
      TDO_EN <= (state == SH_IR) || (state == SH_DR);
      if (state == SH_IR) begin
        TDO <= ir_sr[0];
      end else if (state == SH_DR) begin
        TDO <= dr_tdo;
      end else begin
        TDO <= 1'b0;
      end
    end
  end

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
IEEE 1149.1-style TAP controller for the board-level JTAG system. It sequences the 16-state TAP FSM from TMS and owns the instruction register (IR). It also owns the BYPASS and IDCODE data registers. It decodes the IR into DR selects and DR control strobes, and muxes the selected DR onto TDO for the user logic in the onboard top level.

Parameters:
IR_WIDTH, 4, instruction register width in bits (>=2)
OP_IDCODE, 4'b0001, IDCODE opcode (low IR_WIDTH bits used)
OP_USER, 4'b0010, opcode selecting the external user DR
IDCODE_VALUE, 32'h1234_5679, 32-bit device ID; bit0 must be 1

Ports:
TCK  in  1  JTAG clock; the only clock
TRST  in  1  asynchronous active-low reset
TMS  in  1  mode select, sampled on rising TCK
TDI  in  1  serial data in, sampled on rising TCK
TDO  out  1  serial data out, updated on falling TCK
TDO_EN  out  1  high while in SHIFT_IR/SHIFT_DR (falling-edge registered)
STATE  out  4  current TAP state code
IR  out  IR_WIDTH  active (updated) instruction
SEL_USER  out  1  IR==OP_USER
CAPTURE_DR  out  1  STATE==CAPTURE_DR and SEL_USER
SHIFT_DR  out  1  STATE==SHIFT_DR and SEL_USER
UPDATE_DR  out  1  STATE==UPDATE_DR and SEL_USER
USER_TDO  in  1  serial output of the external user DR

Behaviour:
- State codes: TLR=0, IDLE=1, SEL_DR=2, CAP_DR=3, SH_DR=4, EX1_DR=5, PA_DR=6, EX2_DR=7, UPD_DR=8, SEL_IR=9, CAP_IR=10, SH_IR=11, EX1_IR=12, PA_IR=13, EX2_IR=14, UPD_IR=15.
- Transitions on rising TCK, (TMS=0 / TMS=1):
  - TLR: IDLE/TLR. IDLE: IDLE/SEL_DR. SEL_DR: CAP_DR/SEL_IR. SEL_IR: CAP_IR/TLR.
  - CAP_x: SH_x/EX1_x. SH_x: SH_x/EX1_x. EX1_x: PA_x/UPD_x. PA_x: PA_x/EX2_x. EX2_x: SH_x/UPD_x. UPD_x: IDLE/SEL_DR.
- Five consecutive TMS=1 rising edges reach TLR from any state.
- TRST low (asynchronous, including mid-shift):
  - STATE=TLR, IR=default, TDO=0, TDO_EN=0.
  - IR shift register = {..0,1}, BYPASS=0, IDCODE shifter=IDCODE_VALUE.
- In TLR (synchronous): IR = default on the falling TCK.
- IR shift register, rising TCK:
  - CAP_IR loads {zeros, 2'b01}.
  - SH_IR shifts right: TDI enters the MSB, the LSB goes to TDO.
- IR update: active IR loads the shift register on falling TCK while in UPD_IR. IR is stable otherwise; SEL_*/strobes change only on that falling edge.
- Decode: OP_USER -> user DR; OP_IDCODE -> IDCODE (when enabled); all other opcodes, including all-ones -> BYPASS.
- BYPASS, rising TCK: 1 bit; CAP_DR loads 0; SH_DR loads TDI.
- IDCODE, rising TCK: 32-bit; CAP_DR loads IDCODE_VALUE; SH_DR shifts right with TDI into bit31.
- TDO mux, registered on falling TCK:
  - SH_IR -> IR shift LSB.
  - SH_DR -> LSB of the selected DR (USER_TDO for user).
  - Otherwise TDO=0.
  - Result: one bit of latency, TDI to TDO through BYPASS.
- PAUSE states hold all shift registers unchanged.
- Strobes are combinational from STATE and registered IR; no glitch requirement beyond that.

Optional Feature:
IDCODE_EN
- Defined: IDCODE register present; reset/TLR default IR = OP_IDCODE.
- Undefined: no IDCODE register; OP_IDCODE decodes as BYPASS; default IR = all-ones (BYPASS).

Test Plan:
- TRST low, then high, TMS=0 x1 -> STATE=1 (IDLE); with IDCODE_EN, IR=4'b0001, else 4'b1111.
- IR scan: TMS 1,1,0,0, then shift TDI=1,1,1,1 with TMS=1 on the 4th bit, TMS=1, TMS=0 -> TDO during the shift = 1,0,0,0; IR=4'b1111, STATE=IDLE.
- BYPASS scan after IR=1111: TMS 1,0,0, then TDI 1,0,1,0 (TMS=1 on the last bit) -> TDO sequence 0,1,0,1 on successive falling edges; STATE goes EX1_DR -> UPD_DR.
- With IDCODE_EN: after reset, DR scan of 32 bits of TDI=0 -> TDO emits IDCODE_VALUE LSB-first, the first bit = 1.
- IR=OP_USER, DR scan -> CAPTURE_DR high exactly 1 cycle, SHIFT_DR high N cycles, UPDATE_DR high 1 cycle; TDO follows USER_TDO.
- Mid SH_DR, pull TRST low for 3 ns -> STATE=0, TDO=0, TDO_EN=0 immediately. Separately, TMS=1 for 5 rising edges from SH_IR -> STATE=0.
